// File: rtl/mc_mem_sim_if.sv
// mc_mem_sim_if
// Request/response bus between a bps core and its memory controller.
//   master : the bps side; drives requests and the response stall.
//   slave  : the memory side; drives request stall and responses.
// Signals:
//   mc_req_ld, mc_req_st   load / store request strobes
//   mc_req_vadr[47:0]      byte address
//   mc_req_wrd_rdctl[63:0] store data, or load tag in bits [31:0]
//   mc_req_stall           request backpressure from memory
//   mc_rsp_push            response valid (consumed the same cycle)
//   mc_rsp_rdctl[31:0]     response tag
//   mc_rsp_data[63:0]      response data
//   mc_rsp_stall           consumer backpressure
interface mc_mem_sim_if;
    logic        mc_req_ld;
    logic        mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd_rdctl;
    logic        mc_req_stall;
    logic        mc_rsp_push;
    logic [31:0] mc_rsp_rdctl;
    logic [63:0] mc_rsp_data;
    logic        mc_rsp_stall;

    modport master (
        output mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, mc_rsp_stall,
        input  mc_req_stall, mc_rsp_push, mc_rsp_rdctl, mc_rsp_data
    );

    modport slave (
        input  mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, mc_rsp_stall,
        output mc_req_stall, mc_rsp_push, mc_rsp_rdctl, mc_rsp_data
    );
endinterface

// File: rtl/mc_mem_sim.sv
// mc_mem_sim
// Memory-controller stand-in for a bps core: word-addressed memory with a
// configurable load latency, a bounded response FIFO guarded by credits,
// optional periodic stall injection, traffic/error counters and a debug
// side port for preloading and inspecting memory.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   mc (slave)        request/response bus, see mc_mem_sim_if
//   dbg_we/addr/wdata side-port write
//   dbg_rdata         side-port registered read data
//   err               sticky protocol/address error
//   ld_count/st_count accepted load/store counters (wrap)
module mc_mem_sim #(
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 1,
    parameter int FIFO_DEPTH  = 8,
    parameter int STALL_EVERY = 0,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_mem_sim_if.slave   mc,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [63:0]   dbg_wdata,
    output logic [63:0]   dbg_rdata,
    output logic          err,
    output logic [31:0]   ld_count,
    output logic [31:0]   st_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    logic [63:0] mem [DEPTH];

    logic [44:0]   reqIdx;
    logic          inRange;
    logic          ldAcc;
    logic          stAcc;
    logic          reqErr;
    logic [63:0]   ldData;
    logic          inject;

    logic          wrValid;
    logic [31:0]   wrTag;
    logic [63:0]   wrData;

    logic [31:0]   fTag_q  [FIFO_DEPTH];
    logic [63:0]   fData_q [FIFO_DEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [OW-1:0] fCnt_q, fCnt_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          pop;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign reqIdx  = mc.mc_req_vadr[47:3];
    assign inRange = (reqIdx < 45'(DEPTH));
    assign ldAcc   = mc.mc_req_ld & ~mc.mc_req_st & ~mc.mc_req_stall;
    assign stAcc   = mc.mc_req_st & ~mc.mc_req_ld & ~mc.mc_req_stall;
    // Out-of-range loads still produce a response, just with zero data.
    assign ldData  = inRange ? mem[reqIdx[AW-1:0]] : 64'd0;
    // Both strobes together, an out-of-range index or a misaligned address
    // are flagged only when the request would otherwise have been taken.
    assign reqErr  = ~mc.mc_req_stall &
                     ((mc.mc_req_ld & mc.mc_req_st) |
                      ((mc.mc_req_ld ^ mc.mc_req_st) &
                       (~inRange | (mc.mc_req_vadr[2:0] != 3'b000))));

    // Stall is built only from registered state so a requester can never
    // form a combinational loop through it.
    assign mc.mc_req_stall = (outstanding_q >= OW'(FIFO_DEPTH)) | inject;

    assign pop             = (fCnt_q != '0) & ~mc.mc_rsp_stall;
    assign mc.mc_rsp_push  = pop;
    assign mc.mc_rsp_rdctl = pop ? fTag_q[rdPtr_q]  : 32'd0;
    assign mc.mc_rsp_data  = pop ? fData_q[rdPtr_q] : 64'd0;

    // Load pipe: with LATENCY 1 the accept edge writes the FIFO directly,
    // otherwise LATENCY-1 register stages delay the FIFO write.
    if (LATENCY == 1) begin : g_direct
        assign wrValid = ldAcc;
        assign wrTag   = mc.mc_req_wrd_rdctl[31:0];
        assign wrData  = ldData;
    end else begin : g_pipe
        logic [LATENCY-2:0] pipeV_q;
        logic [31:0]        pipeTag_q  [LATENCY-1];
        logic [63:0]        pipeData_q [LATENCY-1];

        // Valid bits are reset so in-flight loads vanish on reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipeV_q <= '0;
            end else begin
                pipeV_q[0] <= ldAcc;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipeV_q[i] <= pipeV_q[i-1];
                end
            end
        end

        // Payload only matters when its valid bit is set, so no reset.
        always_ff @(posedge clk) begin
            pipeTag_q[0]  <= mc.mc_req_wrd_rdctl[31:0];
            pipeData_q[0] <= ldData;
            for (int i = 1; i < LATENCY - 1; i++) begin
                pipeTag_q[i]  <= pipeTag_q[i-1];
                pipeData_q[i] <= pipeData_q[i-1];
            end
        end

        assign wrValid = pipeV_q[LATENCY-2];
        assign wrTag   = pipeTag_q[LATENCY-2];
        assign wrData  = pipeData_q[LATENCY-2];
    end

    // Free-running phase counter; the last phase of each period stalls.
    if (STALL_EVERY > 0) begin : g_inject
        logic [31:0] injCnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                injCnt_q <= '0;
            end else begin
                injCnt_q <= (injCnt_q == 32'(STALL_EVERY - 1)) ? 32'd0 : injCnt_q + 32'd1;
            end
        end

        assign inject = (injCnt_q == 32'(STALL_EVERY - 1));
    end else begin : g_noinject
        assign inject = 1'b0;
    end

    // Pointer, fill and credit bookkeeping. Outstanding counts loads from
    // accept to pop, covering both the pipe and the FIFO.
    always_comb begin
        rdPtr_d       = rdPtr_q;
        wrPtr_d       = wrPtr_q;
        fCnt_d        = fCnt_q + OW'(wrValid) - OW'(pop);
        outstanding_d = outstanding_q + OW'(ldAcc) - OW'(pop);
        if (wrValid) begin
            wrPtr_d = ptrInc(wrPtr_q);
        end
        if (pop) begin
            rdPtr_d = ptrInc(rdPtr_q);
        end
    end

    // Control state, counters, error flag and side-port read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            fCnt_q        <= '0;
            outstanding_q <= '0;
            err           <= 1'b0;
            ld_count      <= 32'd0;
            st_count      <= 32'd0;
            dbg_rdata     <= 64'd0;
        end else begin
            rdPtr_q       <= rdPtr_d;
            wrPtr_q       <= wrPtr_d;
            fCnt_q        <= fCnt_d;
            outstanding_q <= outstanding_d;
            if (reqErr) begin
                err <= 1'b1;
            end
            if (ldAcc) begin
                ld_count <= ld_count + 32'd1;
            end
            if (stAcc) begin
                st_count <= st_count + 32'd1;
            end
            dbg_rdata <= mem[dbg_addr];
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clk) begin
        if (wrValid) begin
            fTag_q[wrPtr_q]  <= wrTag;
            fData_q[wrPtr_q] <= wrData;
        end
    end

    // Memory array; the port store is written last so it wins a collision
    // with the side port.
    always_ff @(posedge clk) begin
        if (dbg_we) begin
            mem[dbg_addr] <= dbg_wdata;
        end
        if (stAcc && inRange) begin
            mem[reqIdx[AW-1:0]] <= mc.mc_req_wrd_rdctl;
        end
    end
endmodule

// File: doc/mc_mem_sim.md
# mc_mem_sim

Parametrised, synthesizable model of the memory-controller port that the `bps` core drives (`mc_req_*` / `mc_rsp_*`). It supersedes the fixed single-cycle array used in simulation. It adds:
- a configurable load-response latency
- a bounded response FIFO with credit-based `mc_req_stall`
- honouring of `mc_rsp_stall`
- periodic stall injection
- error and traffic counters
- a side port for preloading and checking memory contents

It sits between a `bps` instance and the test harness, or on an FPGA as an on-chip stand-in for real memory.

## Interface
Parameters:
- `DEPTH`, 1024: number of 64-bit words; address index = `mc_req_vadr[47:3]`.
- `LATENCY`, 1: cycles from load accept to the response becoming poppable; must be ≥1.
- `FIFO_DEPTH`, 8: maximum outstanding loads (in the pipe plus in the FIFO); must be ≥1.
- `STALL_EVERY`, 0: if nonzero, `mc_req_stall` is forced high one cycle in every `STALL_EVERY` cycles; 0 disables injection.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mc_req_ld` in 1: load request.
- `mc_req_st` in 1: store request.
- `mc_req_vadr` in 48: byte address.
- `mc_req_wrd_rdctl` in 64: store data for stores; bits [31:0] are the rdctl tag for loads.
- `mc_req_stall` out 1: request backpressure.
- `mc_rsp_rdctl` out 32: tag of the response at the FIFO head.
- `mc_rsp_data` out 64: data of the response at the FIFO head.
- `mc_rsp_push` out 1: response valid; the response is consumed in the same cycle.
- `mc_rsp_stall` in 1: consumer backpressure.
- `dbg_we` in 1: side-port write enable.
- `dbg_addr` in log2(DEPTH): side-port word address.
- `dbg_wdata` in 64: side-port write data.
- `dbg_rdata` out 64: side-port read data, registered.
- `err` out 1: sticky protocol/address error.
- `ld_count` out 32: count of accepted loads.
- `st_count` out 32: count of accepted stores.

## Operation
- **Accept rule:** a request is accepted on an edge where exactly one of `mc_req_ld` / `mc_req_st` is high and `mc_req_stall` is low.
  - If both are high: neither is performed and `err` is set.
  - A request presented while `mc_req_stall` is high is ignored. The requester must hold it.
- **Store:** `mem[idx] <= wrd_rdctl` at the accept edge; `st_count` increments.
- **Load:**
  - `mem[idx]` is read at the accept edge, so a load accepted after a store to the same index returns the new data.
  - The data and tag enter a `LATENCY`-stage valid pipe; the last stage writes into the FIFO.
  - `ld_count` increments.
- **Address checks:**
  - If `idx >= DEPTH`: a load returns data 0 with its tag preserved, a store is dropped, and `err` is set.
  - If `vadr[2:0] != 0`: `err` is set and the address is truncated.
- **Response:** `mc_rsp_push = !fifo_empty && !mc_rsp_stall`. When push is high, `rdctl`/`data` show the FIFO head and the entry is popped at that edge. When push is low, `rdctl` and `data` read 0.
- **Credit:**
  - A counter `outstanding` tracks loads in flight: +1 on each load accept, −1 on each pop; both in the same cycle leave it unchanged.
  - `mc_req_stall = (outstanding >= FIFO_DEPTH) || inject`.
  - `mc_req_stall` depends only on registered state, never on same-cycle inputs.
  - The FIFO therefore never overflows. Stores are stalled too while credit is exhausted.
- **Injection:** a free-running counter modulo `STALL_EVERY` drives `inject`; `inject` is high when the counter equals `STALL_EVERY-1`.
- **Side port:**
  - If `dbg_we`: `mem[dbg_addr] <= dbg_wdata`.
  - `dbg_rdata <= mem[dbg_addr]` every cycle; for a write in the same cycle this returns the old data.
  - The side port must not be used while requests are active; a collision with a port store leaves the port store winning.
- **Error flag:** `err` is cleared only by reset.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - Outputs: `mc_req_stall`=0, `mc_rsp_push`=0, `mc_rsp_rdctl`=0, `mc_rsp_data`=0, `dbg_rdata`=0, `err`=0, `ld_count`=0, `st_count`=0.
  - Internal state: pipe valids, FIFO pointers, `outstanding` and the injection counter all cleared.
  - Memory contents are not reset.
- **Reset mid-operation:** in-flight loads are discarded and no response is pushed after reset release.
- **Load latency:** for a load accepted at edge E with an empty FIFO and `mc_rsp_stall`=0, `mc_rsp_push` is high during the cycle after edge E+LATENCY−1. With `LATENCY`=1 that is the cycle immediately after accept.
- **Throughput:** one request accepted per cycle and one response popped per cycle. Responses are returned in accept order.
- **FIFO full and pop in the same cycle:** the pop frees a credit, and `mc_req_stall` falls on the following cycle.
- **Counters:** `ld_count` and `st_count` wrap modulo 2^32.

## Test plan
- **Basic load/store:** `LATENCY`=1; preload mem[3]=0xDEAD via the side port, then issue a load at vadr 0x18 with tag 0x55 → push the next cycle with data 0xDEAD, rdctl 0x55. Then store 0x1234 at 0x18 and load → 0x1234.
- **Latency and ordering:** `LATENCY`=4; issue 3 back-to-back loads with tags 1, 2, 3 → pushes on 3 consecutive cycles, starting 4 cycles after the first accept, in tag order 1, 2, 3.
- **Credit backpressure:** `FIFO_DEPTH`=2; hold `mc_rsp_stall`=1 and issue loads every cycle → `mc_req_stall`=1 after 2 accepts. Release `mc_rsp_stall` → 2 pushes occur, stall drops, and no load is lost or duplicated (`ld_count` equals pushes).
- **Errors:** present ld and st together → `err`=1, no memory change, no push. A load to idx=`DEPTH` → push data 0 with its tag, `err`=1.
- **Injection:** `STALL_EVERY`=4 with no loads → `mc_req_stall` high exactly 1 cycle in 4; held requests are accepted only on unstalled cycles.
- **Async reset:** drop `rst_n` mid-cycle with 3 loads outstanding → outputs go to 0 immediately; after release, no pushes occur and the counters read 0.
